// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction buffer between fetch and decode with branch hold and flush
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   fetch_valid_i/instr_i/pc_i        fetch push side, accepted when fetch_ready_o
//   fetch_ready_o                     queue not full
//   dec_valid_o/instr_o/pc_o          head entry offered to decode
//   dec_ready_i                       decode consumes the head
//   dec_is_branch_i                   head is branch-class; its pop stalls issue
//   branch_resolved_i                 pulse releasing the branch stall
//   flush_i                           pulse discarding all contents
//   count_o                           occupancy, 0..DEPTH
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int AW    = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       fetch_valid_i,
    input  logic [IW-1:0]              fetch_instr_i,
    input  logic [AW-1:0]              fetch_pc_i,
    output logic                       fetch_ready_o,
    output logic                       dec_valid_o,
    output logic [IW-1:0]              dec_instr_o,
    output logic [AW-1:0]              dec_pc_o,
    input  logic                       dec_ready_i,
    input  logic                       dec_is_branch_i,
    input  logic                       branch_resolved_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {ST_RUN, ST_HOLD} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   instr_mem [DEPTH];
    logic [AW-1:0]   pc_mem    [DEPTH];
    logic            push, pop;

    // Outputs depend on registered state only; full blocks fetch even if a pop happens.
    assign fetch_ready_o = (count_q != CW'(DEPTH));
    assign dec_valid_o   = (state_q == ST_RUN) && (count_q != '0);
    assign dec_instr_o   = instr_mem[rd_ptr_q];
    assign dec_pc_o      = pc_mem[rd_ptr_q];
    assign count_o       = count_q;

    // Flush overrides any concurrent handshake.
    assign push = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop  = dec_valid_o & dec_ready_i & ~flush_i;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            state_d  = ST_RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                ST_RUN:  if (pop && dec_is_branch_i) state_d = ST_HOLD;
                ST_HOLD: if (branch_resolved_i)      state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only occupancy tracking is.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= fetch_instr_i;
            pc_mem[wr_ptr_q]    <= fetch_pc_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    logic        clk;
    logic        reset_n;
    logic        fetch_valid_i;
    logic [31:0] fetch_instr_i;
    logic [63:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [63:0] dec_pc_o;
    logic        dec_ready_i;
    logic        dec_is_branch_i;
    logic        branch_resolved_i;
    logic        flush_i;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4), .IW(32), .AW(64)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .fetch_valid_i     (fetch_valid_i),
        .fetch_instr_i     (fetch_instr_i),
        .fetch_pc_i        (fetch_pc_i),
        .fetch_ready_o     (fetch_ready_o),
        .dec_valid_o       (dec_valid_o),
        .dec_instr_o       (dec_instr_o),
        .dec_pc_o          (dec_pc_o),
        .dec_ready_i       (dec_ready_i),
        .dec_is_branch_i   (dec_is_branch_i),
        .branch_resolved_i (branch_resolved_i),
        .flush_i           (flush_i),
        .count_o           (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fetch_valid_i = 1'b0; fetch_instr_i = '0; fetch_pc_i = '0;
        dec_ready_i = 1'b0; dec_is_branch_i = 1'b0;
        branch_resolved_i = 1'b0; flush_i = 1'b0;
        #1;
        step(); step();
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", fetch_ready_o); end
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", dec_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_valid_i = 1'b1; fetch_pc_i = 64'(i * 4); fetch_instr_i = 32'hA0 + 32'(i);
            step();
            checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count_o, i + 1); end
        end
        fetch_valid_i = 1'b0;
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %0b exp 0", fetch_ready_o); end
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (dec_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid got %0b exp 1", dec_valid_o); end
            checks++; if (dec_pc_o !== 64'(i * 4)) begin errors++; $display("FAIL drain_pc got %0h exp %0h", dec_pc_o, i * 4); end
            checks++; if (dec_instr_o !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL drain_instr got %0h exp %0h", dec_instr_o, 32'hA0 + i); end
            step();
        end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count_o); end
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %0b exp 0", dec_valid_o); end
        dec_ready_i = 1'b0;
    endtask

    task automatic test_stream();
        dec_ready_i = 1'b1;
        fetch_valid_i = 1'b1; fetch_pc_i = 64'h100; fetch_instr_i = 32'h100;
        step();
        for (int k = 1; k <= 20; k++) begin
            fetch_pc_i = 64'h100 + 64'(4 * k); fetch_instr_i = 32'h100 + 32'(k);
            checks++; if (dec_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid got %0b exp 1", dec_valid_o); end
            checks++; if (dec_pc_o !== 64'h100 + 64'(4 * (k - 1))) begin errors++; $display("FAIL stream_pc got %0h exp %0h", dec_pc_o, 64'h100 + 64'(4 * (k - 1))); end
            checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL stream_count got %0d exp 1", count_o); end
            step();
        end
        fetch_valid_i = 1'b0;
        checks++; if (dec_pc_o !== 64'h150) begin errors++; $display("FAIL stream_last_pc got %0h exp 150", dec_pc_o); end
        step();
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL stream_end_count got %0d exp 0", count_o); end
        dec_ready_i = 1'b0;
    endtask

    task automatic test_branch_hold();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_valid_i = 1'b1; fetch_pc_i = 64'h10 + 64'(4 * i); fetch_instr_i = 32'hB0 + 32'(i);
            step();
        end
        fetch_valid_i = 1'b0;
        dec_ready_i = 1'b1; dec_is_branch_i = 1'b1;
        checks++; if (dec_pc_o !== 64'h10) begin errors++; $display("FAIL branch_head_pc got %0h exp 10", dec_pc_o); end
        step();
        dec_is_branch_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL hold_valid got %0b exp 0", dec_valid_o); end
            checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL hold_count got %0d exp 2", count_o); end
            step();
        end
        branch_resolved_i = 1'b1;
        step();
        branch_resolved_i = 1'b0; dec_ready_i = 1'b0;
        checks++; if (dec_valid_o !== 1'b1) begin errors++; $display("FAIL resolve_valid got %0b exp 1", dec_valid_o); end
        checks++; if (dec_pc_o !== 64'h14) begin errors++; $display("FAIL resolve_pc got %0h exp 14", dec_pc_o); end
    endtask

    task automatic test_flush_collision();
        // Queue holds 0x14, 0x18; add 0x1C, then pop branch 0x14 while pushing 0x20.
        fetch_valid_i = 1'b1; fetch_pc_i = 64'h1C; fetch_instr_i = 32'hB3;
        step();
        fetch_pc_i = 64'h20; fetch_instr_i = 32'hB4;
        dec_ready_i = 1'b1; dec_is_branch_i = 1'b1;
        checks++; if (dec_pc_o !== 64'h14) begin errors++; $display("FAIL flush_pre_pc got %0h exp 14", dec_pc_o); end
        step();
        dec_is_branch_i = 1'b0; dec_ready_i = 1'b0;
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count_o); end
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_pre_hold got %0b exp 0", dec_valid_o); end
        flush_i = 1'b1; branch_resolved_i = 1'b1;
        fetch_valid_i = 1'b1; fetch_pc_i = 64'h40; fetch_instr_i = 32'hC0;
        step();
        flush_i = 1'b0; branch_resolved_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", fetch_ready_o); end
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", dec_valid_o); end
        fetch_pc_i = 64'h50; fetch_instr_i = 32'hC1;
        step();
        fetch_valid_i = 1'b0;
        checks++; if (dec_valid_o !== 1'b1) begin errors++; $display("FAIL post_flush_run got %0b exp 1", dec_valid_o); end
        checks++; if (dec_pc_o !== 64'h50) begin errors++; $display("FAIL post_flush_pc got %0h exp 50", dec_pc_o); end
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL post_flush_count got %0d exp 1", count_o); end
        dec_ready_i = 1'b1;
        step();
        dec_ready_i = 1'b0;
    endtask

    task automatic test_full_pop();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_valid_i = 1'b1; fetch_pc_i = 64'h60 + 64'(4 * i); fetch_instr_i = 32'hD0 + 32'(i);
            step();
        end
        fetch_pc_i = 64'h70; fetch_instr_i = 32'hD4;
        dec_ready_i = 1'b1;
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", fetch_ready_o); end
        step();
        fetch_valid_i = 1'b0;
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d exp 3", count_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %0b exp 1", fetch_ready_o); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (dec_pc_o !== 64'h60 + 64'(4 * i)) begin errors++; $display("FAIL full_drain_pc got %0h exp %0h", dec_pc_o, 64'h60 + 64'(4 * i)); end
            step();
        end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL full_drain_count got %0d exp 0", count_o); end
        dec_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            fetch_valid_i = 1'b1; fetch_pc_i = 64'h80 + 64'(4 * i); fetch_instr_i = 32'hE0 + 32'(i);
            step();
        end
        fetch_valid_i = 1'b0;
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL arst_pre_count got %0d exp 2", count_o); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", count_o); end
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b exp 0", dec_valid_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready got %0b exp 1", fetch_ready_o); end
        #3 reset_n = 1'b1;
        step();
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL arst_after_count got %0d exp 0", count_o); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_branch_hold();
        test_flush_collision();
        test_full_pop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
